// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream beat, downstream beat, flush and fill level.
// The block uses the slave view; the producer/consumer side uses the master view.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 64
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer; every output is decoded from
// registers only, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
    parameter int WIDTH    = 64,
    parameter bit CLR_ZERO = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_reg_if.slave bus
);
    // State encoding equals the number of held beats.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] main_d_r;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] skid_d_r;
    logic [WIDTH-1:0] skid_d_s;
    logic             in_fire_s;
    logic             out_fire_s;

    assign bus.in_ready  = (state_r != ST_TWO);
    assign bus.out_valid = (state_r != ST_EMPTY);
    assign bus.out_data  = main_d_r;
    assign bus.occupancy = state_r;

    assign in_fire_s  = bus.in_valid & (state_r != ST_TWO);
    assign out_fire_s = (state_r != ST_EMPTY) & bus.out_ready;

    // Next-state and next-data decode, with flush overriding normal operation.
    always_comb begin
        state_s  = state_r;
        main_d_s = main_d_r;
        skid_d_s = skid_d_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_s  = ST_ONE;
                    main_d_s = bus.in_data;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_d_s = bus.in_data;
                end else if (in_fire_s) begin
                    state_s  = ST_TWO;
                    skid_d_s = bus.in_data;
                end else if (out_fire_s) begin
                    state_s = ST_EMPTY;
                    if (CLR_ZERO) begin
                        main_d_s = {WIDTH{1'b0}};
                    end else begin
                        main_d_s = main_d_r;
                    end
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_fire_s) begin
                    state_s  = ST_ONE;
                    main_d_s = skid_d_r;
                    if (CLR_ZERO) begin
                        skid_d_s = {WIDTH{1'b0}};
                    end else begin
                        skid_d_s = skid_d_r;
                    end
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s  = ST_EMPTY;
                main_d_s = {WIDTH{1'b0}};
                skid_d_s = {WIDTH{1'b0}};
            end
        endcase

        // A beat delivered in the flush cycle has already left; the incoming one is dropped.
        if (bus.flush) begin
            state_s = ST_EMPTY;
            if (CLR_ZERO) begin
                main_d_s = {WIDTH{1'b0}};
                skid_d_s = {WIDTH{1'b0}};
            end else begin
                main_d_s = main_d_r;
                skid_d_s = skid_d_r;
            end
        end else begin
            state_s = state_s;
        end
    end

    // State and payload registers; reset always clears the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_EMPTY;
            main_d_r <= {WIDTH{1'b0}};
            skid_d_r <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            main_d_r <= main_d_s;
            skid_d_r <= skid_d_s;
        end
    end
endmodule
